// File: rtl/relogio_pkg.sv
// Shared types, limits and segment codes for the HH:MM digital clock.
package relogio_pkg;

  typedef enum logic [1:0] {
    NORMAL      = 2'b00,
    AJUSTE_MIN  = 2'b01,
    AJUSTE_HORA = 2'b10
  } mode_e;

  typedef struct packed {
    logic [3:0] dez;
    logic [3:0] uni;
  } bcd2_t;

  localparam logic [5:0] MAX_SEC  = 6'd59;
  localparam logic [6:0] MAX_MIN  = 7'd59;
  localparam logic [6:0] MAX_HORA = 7'd23;

  // Active-low segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Two-digit BCD increment that wraps to 00 once the value reaches max_val.
  function automatic bcd2_t bcd2_inc(input bcd2_t v, input logic [6:0] max_val);
    bcd2_t      r;
    logic [6:0] valor;
    valor = 7'(v.dez) * 7'd10 + 7'(v.uni);
    if (valor == max_val) begin
      r.dez = 4'd0;
      r.uni = 4'd0;
    end else if (v.uni == 4'd9) begin
      r.dez = v.dez + 4'd1;
      r.uni = 4'd0;
    end else begin
      r.dez = v.dez;
      r.uni = v.uni + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/relogio_digital_if.sv
// Button inputs and display/LED outputs of the clock, bundled for the top level.
interface relogio_digital_if;
  logic       btn_ajuste;
  logic       btn_inc;
  logic [6:0] display_unidade_min;
  logic [6:0] display_dezena_min;
  logic [6:0] display_unidade_hora;
  logic [6:0] display_dezena_hora;
  logic [7:0] leds;
  logic       seg_ponto;

  modport master (
    output btn_ajuste, btn_inc,
    input  display_unidade_min, display_dezena_min,
    input  display_unidade_hora, display_dezena_hora,
    input  leds, seg_ponto
  );

  modport slave (
    input  btn_ajuste, btn_inc,
    output display_unidade_min, display_dezena_min,
    output display_unidade_hora, display_dezena_hora,
    output leds, seg_ponto
  );
endinterface

// File: rtl/relogio_digital_seg7_decoder.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes blank the digit.
module seg7_decoder
  import relogio_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Segment lookup
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/relogio_digital.sv
// 24-hour HH:MM clock with a two-stage set mode (minutes, then hours) driven
// by two debounced buttons; drives four 7-segment digits, a dot and status LEDs.
module relogio_digital
  import relogio_pkg::*;
#(
  parameter int CLK_HZ = 1
) (
  input  logic               clk,
  input  logic               reset,
  relogio_digital_if.slave   bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  mode_e         mode_r, mode_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [5:0]    ss_r, ss_s;
  bcd2_t         min_r, min_s;
  bcd2_t         hora_r, hora_s;
  logic          ajuste_q_r, inc_q_r;

  logic ajuste_pulse_s, inc_pulse_s, tick_s;

  assign ajuste_pulse_s = bus.btn_ajuste & ~ajuste_q_r;
  assign inc_pulse_s    = bus.btn_inc & ~inc_q_r;
  assign tick_s         = (presc_r == PRESC_MAX);

  // State registers: mode, prescaler, time and button edge history
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r     <= NORMAL;
      presc_r    <= '0;
      ss_r       <= 6'd0;
      min_r      <= '0;
      hora_r     <= '0;
      ajuste_q_r <= 1'b0;
      inc_q_r    <= 1'b0;
    end else begin
      mode_r     <= mode_s;
      presc_r    <= presc_s;
      ss_r       <= ss_s;
      min_r      <= min_s;
      hora_r     <= hora_s;
      ajuste_q_r <= bus.btn_ajuste;
      inc_q_r    <= bus.btn_inc;
    end
  end

  // Next-state: a mode-button pulse takes priority over both counting and inc
  always_comb begin
    mode_s  = mode_r;
    presc_s = presc_r;
    ss_s    = ss_r;
    min_s   = min_r;
    hora_s  = hora_r;
    case (mode_r)
      NORMAL: begin
        if (ajuste_pulse_s) begin
          mode_s = AJUSTE_MIN;
        end else if (tick_s) begin
          presc_s = '0;
          if (ss_r == MAX_SEC) begin
            ss_s  = 6'd0;
            min_s = bcd2_inc(min_r, MAX_MIN);
            if (min_s == '0) begin
              hora_s = bcd2_inc(hora_r, MAX_HORA);
            end else begin
              hora_s = hora_r;
            end
          end else begin
            ss_s = ss_r + 6'd1;
          end
        end else begin
          presc_s = presc_r + PW'(1);
        end
      end
      AJUSTE_MIN: begin
        if (ajuste_pulse_s) begin
          mode_s = AJUSTE_HORA;
        end else if (inc_pulse_s) begin
          min_s = bcd2_inc(min_r, MAX_MIN);
        end else begin
          min_s = min_r;
        end
      end
      AJUSTE_HORA: begin
        if (ajuste_pulse_s) begin
          mode_s  = NORMAL;
          ss_s    = 6'd0;
          presc_s = '0;
        end else if (inc_pulse_s) begin
          hora_s = bcd2_inc(hora_r, MAX_HORA);
        end else begin
          hora_s = hora_r;
        end
      end
      default: mode_s = NORMAL;
    endcase
  end

  // Status LEDs and separator dot decoded from the registered state
  always_comb begin
    bus.leds      = {2'b00, ss_r};
    bus.seg_ponto = 1'b0;
    case (mode_r)
      NORMAL: begin
        bus.leds[7:6] = 2'b00;
        bus.seg_ponto = ss_r[0];
      end
      AJUSTE_MIN:  bus.leds[7:6] = 2'b01;
      AJUSTE_HORA: bus.leds[7:6] = 2'b10;
      default:     bus.leds[7:6] = 2'b00;
    endcase
  end

  seg7_decoder u_dec_min_uni  (.bcd(min_r.uni),  .seg(bus.display_unidade_min));
  seg7_decoder u_dec_min_dez  (.bcd(min_r.dez),  .seg(bus.display_dezena_min));
  seg7_decoder u_dec_hora_uni (.bcd(hora_r.uni), .seg(bus.display_unidade_hora));
  seg7_decoder u_dec_hora_dez (.bcd(hora_r.dez), .seg(bus.display_dezena_hora));

endmodule

// File: tb/tb_relogio_digital.sv
// Self-checking bench for relogio_digital: an integer reference clock predicts
// every cycle's outputs through a scoreboard queue, plus targeted spot checks.
module tb_relogio_digital;

  logic clk = 1'b0;
  logic reset = 1'b0;

  relogio_digital_if bus ();

  relogio_digital #(.CLK_HZ(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  int n_checks = 0;
  int n_errors = 0;

  int   m_hh = 0, m_mm = 0, m_ss = 0, m_mode = 0;
  logic m_aq = 1'b0, m_iq = 1'b0;

  logic [36:0] sb_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [36:0] exp_vec();
    logic [7:0] l;
    logic       p;
    l = {(m_mode == 2) ? 1'b1 : 1'b0, (m_mode == 1) ? 1'b1 : 1'b0, 6'(m_ss)};
    p = (m_mode == 0) ? ((m_ss % 2) == 1) : 1'b0;
    return {l, seg_tab[m_hh / 10], seg_tab[m_hh % 10],
            seg_tab[m_mm / 10], seg_tab[m_mm % 10], p};
  endfunction

  function automatic logic [36:0] obs_vec();
    return {bus.leds, bus.display_dezena_hora, bus.display_unidade_hora,
            bus.display_dezena_min, bus.display_unidade_min, bus.seg_ponto};
  endfunction

  task automatic model_update(input logic a, input logic i, input logic r);
    logic pa, pi;
    if (r) begin
      m_hh = 0; m_mm = 0; m_ss = 0; m_mode = 0; m_aq = 1'b0; m_iq = 1'b0;
    end else begin
      pa = a & ~m_aq;
      pi = i & ~m_iq;
      m_aq = a;
      m_iq = i;
      if (m_mode == 0) begin
        if (pa) m_mode = 1;
        else begin
          m_ss++;
          if (m_ss == 60) begin
            m_ss = 0;
            m_mm++;
            if (m_mm == 60) begin
              m_mm = 0;
              m_hh = (m_hh + 1) % 24;
            end
          end
        end
      end else if (m_mode == 1) begin
        if (pa) m_mode = 2;
        else if (pi) m_mm = (m_mm + 1) % 60;
      end else begin
        if (pa) begin
          m_mode = 0;
          m_ss = 0;
        end else if (pi) m_hh = (m_hh + 1) % 24;
      end
    end
  endtask

  task automatic step(input logic a, input logic i, input logic r);
    logic [36:0] e;
    bus.btn_ajuste = a;
    bus.btn_inc    = i;
    reset          = r;
    @(posedge clk);
    model_update(a, i, r);
    sb_q.push_back(exp_vec());
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk("ciclo", 64'(obs_vec()), 64'(e));
    end
  endtask

  task automatic press(input logic a, input logic i);
    step(a, i, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.btn_ajuste = 1'b0;
    bus.btn_inc    = 1'b0;

    step(1'b0, 1'b0, 1'b1);
    chk("reset_leds", 64'(bus.leds), 64'h00);
    chk("reset_digitos", 64'({bus.display_dezena_hora, bus.display_unidade_hora,
        bus.display_dezena_min, bus.display_unidade_min}), 64'({S0, S0, S0, S0}));
    chk("reset_ponto", 64'(bus.seg_ponto), 64'd0);

    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
    chk("conta5_leds", 64'(bus.leds), 64'h05);
    chk("conta5_ponto", 64'(bus.seg_ponto), 64'd1);

    press(1'b1, 1'b0);
    chk("ajuste_min_leds", 64'(bus.leds), 64'h45);
    press(1'b0, 1'b1);
    chk("inc_min", 64'(bus.display_unidade_min), 64'(S1));
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
    chk("congelado_leds", 64'(bus.leds), 64'h45);
    chk("congelado_min", 64'(bus.display_unidade_min), 64'(S1));

    press(1'b1, 1'b0);
    chk("ajuste_hora_leds", 64'(bus.leds), 64'h85);
    press(1'b0, 1'b1);
    chk("inc_hora", 64'(bus.display_unidade_hora), 64'(S1));
    step(1'b1, 1'b0, 1'b0);
    chk("volta_normal_ss0", 64'(bus.leds), 64'h00);
    step(1'b0, 1'b0, 1'b0);
    chk("retoma_contagem", 64'(bus.leds), 64'h01);

    // 01:01 -> minutes to 59, wrap to 00, then back to 59
    press(1'b1, 1'b0);
    for (int k = 0; k < 58; k++) press(1'b0, 1'b1);
    chk("min59", 64'({bus.display_dezena_min, bus.display_unidade_min}), 64'({S5, S9}));
    press(1'b0, 1'b1);
    chk("min_wrap", 64'({bus.display_dezena_min, bus.display_unidade_min}), 64'({S0, S0}));
    chk("min_wrap_sem_carry", 64'(bus.display_unidade_hora), 64'(S1));
    for (int k = 0; k < 59; k++) press(1'b0, 1'b1);

    press(1'b1, 1'b0);
    for (int k = 0; k < 22; k++) press(1'b0, 1'b1);
    chk("hora23", 64'({bus.display_dezena_hora, bus.display_unidade_hora}), 64'({S2, S3}));
    press(1'b0, 1'b1);
    chk("hora_wrap", 64'({bus.display_dezena_hora, bus.display_unidade_hora}), 64'({S0, S0}));
    for (int k = 0; k < 23; k++) press(1'b0, 1'b1);

    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 59; k++) step(1'b0, 1'b0, 1'b0);
    chk("23_59_59", 64'({bus.leds, bus.display_dezena_hora, bus.display_unidade_hora,
        bus.display_dezena_min, bus.display_unidade_min}), 64'({8'd59, S2, S3, S5, S9}));
    step(1'b0, 1'b0, 1'b0);
    chk("meia_noite", 64'({bus.leds, bus.display_dezena_hora, bus.display_unidade_hora,
        bus.display_dezena_min, bus.display_unidade_min}), 64'({8'h00, S0, S0, S0, S0}));

    step(1'b1, 1'b1, 1'b0);
    chk("simult_modo", 64'(bus.leds[7:6]), 64'd1);
    chk("simult_sem_inc", 64'(bus.display_unidade_min), 64'(S0));
    step(1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("inc_segurado", 64'(bus.display_unidade_min), 64'(S1));

    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("pre_reset_hora", 64'(bus.display_unidade_hora), 64'(S1));
    step(1'b0, 1'b0, 1'b1);
    chk("reset_ajuste", 64'({bus.leds, bus.display_dezena_hora, bus.display_unidade_hora,
        bus.display_dezena_min, bus.display_unidade_min, bus.seg_ponto}),
        64'({8'h00, S0, S0, S0, S0, 1'b0}));
    step(1'b0, 1'b0, 1'b0);
    chk("pos_reset_conta", 64'(bus.leds), 64'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/relogio_digital.md
Name: relogio_digital

Overview:
24-hour HH:MM digital clock with a button-driven time-set mode. It counts seconds, minutes and hours from a slow system clock and drives four 7-segment digits (HH:MM). It also drives a blinking separator dot and eight status LEDs. It sits at board top level; buttons arrive already debounced and synchronous to clk.

Parameters:
CLK_HZ, 1, clk cycles per second (prescaler terminal count = CLK_HZ-1); must be >= 1

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high; clears time and mode
btn_ajuste  input  1  mode button, active-high level; acts on rising edge
btn_inc  input  1  increment button, active-high level; acts on rising edge
display_unidade_min  output  7  minutes ones digit, segments {g,f,e,d,c,b,a}, active-low
display_dezena_min  output  7  minutes tens digit, same encoding
display_unidade_hora  output  7  hours ones digit, same encoding
display_dezena_hora  output  7  hours tens digit, same encoding
leds  output  8  [5:0] seconds binary, [6] AJUSTE_MIN active, [7] AJUSTE_HORA active
seg_ponto  output  1  separator dot, active-low

Behaviour:
- Reset (sync, high) forces hh=00, mm=00, ss=00, prescaler=0, mode=NORMAL, edge registers=0.
- After reset: all four digits = 7'b1000000 ('0'), leds=8'h00, seg_ponto=0.
- Reset mid-adjust has the same effect: returns to NORMAL at 00:00:00.
- Edge detect: one register per button; pulse = btn & ~btn_q.
- A pulse acts on the same rising edge on which the high level is first sampled.
- Holding a button produces a single pulse.
- Prescaler counts 0..CLK_HZ-1; tick is asserted when count = CLK_HZ-1. With CLK_HZ=1, every cycle is a tick.
- Mode FSM, advanced by an ajuste pulse: NORMAL -> AJUSTE_MIN -> AJUSTE_HORA -> NORMAL.
- NORMAL:
  - Each tick increments ss.
  - ss=59 -> 0 with carry to mm; mm=59 -> 0 with carry to hh; hh=23 -> 0.
  - 23:59:59 + tick = 00:00:00.
  - inc pulses are ignored.
- AJUSTE_MIN:
  - Prescaler and ss are frozen.
  - inc pulse: mm = (mm+1) mod 60, with no carry into hh.
- AJUSTE_HORA:
  - Prescaler and ss are frozen.
  - inc pulse: hh = (hh+1) mod 24.
- Leaving AJUSTE_HORA to NORMAL clears ss and the prescaler to 0.
- Simultaneous ajuste and inc pulses in one cycle: the mode change wins and the inc is discarded.
- Storage: time held as BCD digits (min ones 0-9, min tens 0-5, hour ones 0-9, hour tens 0-2).
  - Hours wrap when tens=2 and ones=3.
  - Seconds may be binary 0-59.
- Outputs are combinational decodes of registered state and update in the same cycle as the state.
- Active-low segment codes for 0..9:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- seg_ponto:
  - NORMAL: ss[0], so the dot is lit on even seconds and blinks at 0.5 Hz.
  - Adjust modes: constant 0 (lit).
- leds[7:6] = 00 NORMAL, 01 AJUSTE_MIN, 10 AJUSTE_HORA; 11 is never driven.
- Unused FSM encodings recover to NORMAL on the next cycle.

Decomposition:
- Shared package relogio_pkg:
  - mode enum {NORMAL, AJUSTE_MIN, AJUSTE_HORA} (2-bit).
  - SEG_0..SEG_9 active-low constants and SEG_BLANK = 7'b1111111.
  - MAX_SEC=59, MAX_MIN=59, MAX_HORA=23.
- One sub-module: seg7_decoder.
  - 4-bit BCD in, 7-bit active-low segments out.
  - Inputs above 9 decode to SEG_BLANK.
  - Instantiated four times.
- Counters, FSM and edge detectors stay in relogio_digital.

Test Plan:
- Reset for 1 cycle, release, run 5 clocks (CLK_HZ=1) -> leds=8'h05, all digits 1000000, seg_ponto=1.
- btn_ajuste high 1 cycle -> leds[6]=1, ss frozen at 5.
  - Then btn_inc high 1 cycle -> display_unidade_min=1111001 (mm=01).
  - 5 more cycles -> mm unchanged, ss unchanged.
- From AJUSTE_MIN: btn_ajuste pulse -> leds[7]=1; btn_inc pulse -> display_unidade_hora=1111001 (hh=01).
  - Then btn_ajuste pulse -> NORMAL, ss=0, counting resumes.
- Set 23:59 via adjust, return to NORMAL, run 60 ticks -> 00:00 (all digits 1000000), leds[5:0]=0.
- In AJUSTE_MIN with mm=59: inc -> mm=00, hh unchanged; in AJUSTE_HORA with hh=23: inc -> hh=00.
- Edge cases:
  - btn_ajuste and btn_inc asserted in the same cycle -> only the mode advances.
  - btn_inc held 10 cycles -> single increment.
  - reset asserted in AJUSTE_HORA -> NORMAL at 00:00:00 on the next edge.
